// File: rtl/hack_pkg.sv
// Shared constants for the frame demultiplexer: word width, lane count,
// FILL/FULL state encoding and the lane-select decode.
package hack_pkg;

    localparam int WIDTH = 16;
    localparam int WAYS  = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    // One-hot select of the lane addressed by the write pointer.
    function automatic logic [WAYS-1:0] lane_decode(input logic [PTR_W-1:0] ptr);
        lane_decode = '0;
        lane_decode[ptr] = 1'b1;
    endfunction

endpackage

// File: rtl/dmux8way16_frame_if.sv
// Upstream word handshake, frame handoff and lane outputs of the frame demux.
interface dmux8way16_frame_if #(parameter int WIDTH = 16);

    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             frame_ack;
    logic             flush;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic             frame_valid;
    logic [3:0]       fill_count;

    modport master (
        output in, in_valid, frame_ack, flush,
        input  in_ready, a, b, c, d, e, f, g, h, frame_valid, fill_count
    );

    modport slave (
        input  in, in_valid, frame_ack, flush,
        output in_ready, a, b, c, d, e, f, g, h, frame_valid, fill_count
    );

endinterface

// File: rtl/register16_load.sv
// Lane storage: word register with load enable and synchronous clear.
module register16_load #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/dmux8way16_frame.sv
// Collects eight consecutive words into lanes a..h and holds the frame
// until the consumer acknowledges it.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_FILL | accepting words, writing lane at the pointer
//   ST_FULL | all eight lanes written, frame held until ack
module dmux8way16_frame #(
    parameter int WIDTH = hack_pkg::WIDTH,
    parameter int WAYS  = hack_pkg::WAYS
) (
    input logic                clk,
    input logic                reset,
    dmux8way16_frame_if.slave  bus
);

    import hack_pkg::*;

    logic [0:0]       state;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fill_cnt;
    logic             accept;
    logic [WAYS-1:0]  lane_load;
    logic [WIDTH-1:0] lane_q [WAYS];

    assign bus.in_ready    = (state == ST_FILL);
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.frame_valid = (state == ST_FULL);
    assign bus.fill_count  = fill_cnt;

    // A flush in the same cycle drops the word, so it must not reach a lane.
    assign lane_load = lane_decode(wr_ptr) & {WAYS{accept && !bus.flush}};

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            state    <= ST_FILL;
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        fill_cnt <= fill_cnt + 1'b1;
                        if (wr_ptr == PTR_W'(WAYS - 1))
                            state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.frame_ack) begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_FILL;
                    wr_ptr   <= '0;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WAYS; i++) begin : g_lane
        register16_load #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (lane_load[i]),
            .d     (bus.in),
            .q     (lane_q[i])
        );
    end

    assign bus.a = lane_q[0];
    assign bus.b = lane_q[1];
    assign bus.c = lane_q[2];
    assign bus.d = lane_q[3];
    assign bus.e = lane_q[4];
    assign bus.f = lane_q[5];
    assign bus.g = lane_q[6];
    assign bus.h = lane_q[7];

endmodule

// File: tb/tb_dmux8way16_frame.sv
// Self-checking bench for dmux8way16_frame: vector table plus directed sequences.
module tb_dmux8way16_frame;

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic [15:0] din;
        logic        ack;
        logic        fl;
        logic [3:0]  exp_cnt;
        logic        exp_fv;
        logic        exp_rdy;
        int          lane;
        logic [15:0] exp_lane;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   failed;
    vec_t vecs[$];

    dmux8way16_frame_if #(.WIDTH(16)) bus ();

    dmux8way16_frame #(.WIDTH(16), .WAYS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] get_lane(input int idx);
        case (idx)
            0: get_lane = bus.a;
            1: get_lane = bus.b;
            2: get_lane = bus.c;
            3: get_lane = bus.d;
            4: get_lane = bus.e;
            5: get_lane = bus.f;
            6: get_lane = bus.g;
            default: get_lane = bus.h;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [15:0] d,
                         input logic ak, input logic fl);
        reset        = r;
        bus.in_valid = iv;
        bus.in       = d;
        bus.frame_ack = ak;
        bus.flush    = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] cnt,
                               input logic fv, input logic rdy);
        chk({tag, " fill_count"}, 16'(bus.fill_count), 16'(cnt));
        chk({tag, " frame_valid"}, 16'(bus.frame_valid), 16'(fv));
        chk({tag, " in_ready"}, 16'(bus.in_ready), 16'(rdy));
    endtask

    task automatic check_lanes(input string tag, input logic [15:0] exp [8]);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s lane%0d", tag, i), get_lane(i), exp[i]);
    endtask

    task automatic add(input string n, input logic r, input logic iv, input logic [15:0] d,
                       input logic ak, input logic fl, input logic [3:0] cnt,
                       input logic fv, input logic rdy, input int ln, input logic [15:0] lv);
        vec_t v;
        v.name = n; v.rst = r; v.iv = iv; v.din = d; v.ack = ak; v.fl = fl;
        v.exp_cnt = cnt; v.exp_fv = fv; v.exp_rdy = rdy; v.lane = ln; v.exp_lane = lv;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] exp_l [8];
        int          n;

        tests  = 0;
        failed = 0;
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Full frame, backpressure while FULL, ack, then the held word lands in a.
        add("reset", 1, 0, 16'h0000, 0, 0, 4'd0, 0, 1, 0, 16'h0000);
        for (int k = 0; k < 8; k++)
            add($sformatf("fill%0d", k), 0, 1, 16'((k + 1) * 16'h1111), 0, 0,
                4'((k == 7) ? 8 : k + 1), (k == 7), (k != 7), k, 16'((k + 1) * 16'h1111));
        for (int k = 0; k < 5; k++)
            add($sformatf("bp%0d", k), 0, 1, 16'h9999, 0, 0, 4'd8, 1, 0,
                k, 16'((k + 1) * 16'h1111));
        add("ack", 0, 1, 16'h9999, 1, 0, 4'd0, 0, 1, 0, 16'h1111);
        add("after_ack", 0, 1, 16'h9999, 0, 0, 4'd1, 0, 1, 0, 16'h9999);
        add("hold_old", 0, 0, 16'h0000, 0, 0, 4'd1, 0, 1, 7, 16'h8888);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ack, vecs[i].fl);
            step();
            check_state(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_fv, vecs[i].exp_rdy);
            chk({vecs[i].name, " lane"}, get_lane(vecs[i].lane), vecs[i].exp_lane);
        end

        // Flush after 3 words with a simultaneous write of ABCD.
        drive(1, 0, 16'h0000, 0, 0); step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 16'(16'h0101 * (k + 1)), 0, 0); step();
        end
        check_state("pre_flush", 4'd3, 0, 1);
        drive(0, 1, 16'hABCD, 0, 1); step();
        check_state("flush", 4'd0, 0, 1);
        exp_l = '{16'h0101, 16'h0202, 16'h0303, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        check_lanes("flush", exp_l);
        drive(0, 1, 16'h0404, 0, 0); step();
        check_state("post_flush", 4'd1, 0, 1);
        chk("post_flush a", bus.a, 16'h0404);

        // Reset mid-frame after 5 words, with a write pending.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 16'(16'h0505 + 16'h0101 * k), 0, 0); step();
        end
        check_state("pre_reset", 4'd5, 0, 1);
        drive(1, 1, 16'hFFFF, 0, 0); step();
        check_state("mid_reset", 4'd0, 0, 1);
        exp_l = '{default: 16'h0000};
        check_lanes("mid_reset", exp_l);

        // Gaps: in_valid alternates; count steps only on accepted cycles.
        n = 0;
        for (int c = 0; c < 16; c++) begin
            drive(0, (c % 2 == 0), 16'(16'h1000 + c), 0, 0);
            step();
            if (c % 2 == 0) n++;
            check_state($sformatf("gap%0d", c), 4'(n), (n == 8), (n != 8));
        end
        for (int i = 0; i < 8; i++) exp_l[i] = 16'(16'h1000 + 2 * i);
        check_lanes("gap", exp_l);
        drive(0, 0, 16'h0000, 1, 0); step();
        check_state("gap_ack", 4'd0, 0, 1);

        // frame_ack in FILL is ignored; frame completes after 4 more words.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 16'(16'hA000 + k), 0, 0); step();
        end
        drive(0, 0, 16'h0000, 1, 0); step();
        check_state("ack_in_fill", 4'd4, 0, 1);
        for (int k = 4; k < 8; k++) begin
            drive(0, 1, 16'(16'hA000 + k), 0, 0); step();
            check_state($sformatf("ackfill%0d", k), 4'(k + 1), (k == 7), (k != 7));
        end
        for (int i = 0; i < 8; i++) exp_l[i] = 16'(16'hA000 + i);
        check_lanes("ackfill", exp_l);

        // flush together with frame_ack in FULL; lanes keep the frame.
        drive(0, 1, 16'hFFFF, 1, 1); step();
        check_state("flush_ack", 4'd0, 0, 1);
        check_lanes("flush_ack", exp_l);
        drive(0, 1, 16'h5555, 0, 0); step();
        check_state("after_flush_ack", 4'd1, 0, 1);
        chk("after_flush_ack a", bus.a, 16'h5555);
        chk("after_flush_ack b", bus.b, 16'hA001);

        drive(0, 0, 16'h0000, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dmux8way16_frame.md
DMUX8WAY16_FRAME -- requirements
Module: dmux8way16_frame

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-002 SHALL have parameter WAYS, default 8, meaning output lanes per frame; fixed at 8 for this release.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port in, input, 16, meaning the data word offered by the upstream source.
REQ-006 SHALL have port in_valid, input, 1, meaning `in` holds a word to accept.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 SHALL have port frame_ack, input, 1, meaning the consumer has taken the complete frame.
REQ-009 SHALL have port flush, input, 1, meaning discard the partial frame and restart at lane 0.
REQ-010 SHALL have ports a, b, c, d, e, f, g, h, output, 16 each, meaning lane registers 0..7.
REQ-011 SHALL have port frame_valid, output, 1, meaning all 8 lanes hold a complete frame.
REQ-012 SHALL have port fill_count, output, 4, meaning lanes written in the current frame (0..8).

Function
REQ-013 SHALL implement two states: FILL (collecting words) and FULL (frame held).
REQ-014 SHALL drive in_ready = 1 in FILL and 0 in FULL, combinationally from state only, with no dependence on in_valid.
REQ-015 SHALL accept a word on a cycle with in_valid && in_ready; on acceptance, write `in` into the lane given by a 3-bit write pointer (0 = a ... 7 = h), then increment the pointer.
REQ-016 SHALL make the written value visible on its lane output on the cycle after acceptance (1-cycle latency); unwritten lanes hold their value.
REQ-017 SHALL, on acceptance with pointer == 7, wrap the pointer to 0, enter FULL, and assert frame_valid from the next cycle.
REQ-018 SHALL, in FULL, hold a..h and frame_valid = 1 stable, ignoring in_valid, until frame_ack is sampled high.
REQ-019 SHALL, on frame_ack in FULL, return to FILL with fill_count = 0 and frame_valid = 0 on the next cycle; lane outputs keep the old frame until overwritten.
REQ-020 SHALL ignore frame_ack while in FILL.
REQ-021 SHALL, on flush in any state, force FILL, pointer 0, fill_count 0, frame_valid 0 next cycle, leaving lane contents unchanged.
REQ-022 SHALL give flush priority over a simultaneous accepted write: the word is dropped.
REQ-023 SHALL give flush priority over a simultaneous frame_ack in FULL; the result is identical either way.
REQ-024 SHALL keep fill_count equal to the number of accepted words since the last frame start: 0..7 in FILL and 8 in FULL.

Reset
REQ-025 SHALL, with reset high at a clock edge, clear a..h to 16'h0000, pointer to 0, fill_count to 0 and frame_valid to 0, and enter FILL.
REQ-026 SHALL give reset priority over flush, frame_ack and writes, including mid-frame; the partial frame is lost.
REQ-027 SHALL assert in_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-028 SHALL take WIDTH, WAYS and the FILL/FULL state encoding from the shared package hack_pkg.
REQ-029 SHALL implement each lane with sub-module register16_load: a 16-bit register with load enable and synchronous reset, instantiated 8 times.
REQ-030 SHALL generate the eight lane load enables by a 1-of-8 decode of the pointer gated with acceptance.

Verification
REQ-031 SHALL cover full frame: stream 1111, 2222, ... 8888 with in_valid held high -> a..h = 1111..8888, frame_valid rises the cycle after the 8th word, in_ready = 0.
REQ-032 SHALL cover backpressure: in_valid held high with word 9999 while FULL for 5 cycles -> no lane changes; after frame_ack, 9999 lands in `a` and fill_count = 1.
REQ-033 SHALL cover gaps: in_valid toggled 1/0 across 8 words -> lanes fill in order, fill_count steps only on accepted cycles.
REQ-034 SHALL cover flush: flush after 3 words, with a simultaneous write of ABCD -> fill_count 0, ABCD not stored, next word goes to `a`.
REQ-035 SHALL cover reset mid-frame: reset after 5 words -> all lanes 0000, frame_valid 0, in_ready 1 on the next cycle.
REQ-036 SHALL cover ack in FILL: frame_ack pulsed while fill_count = 4 -> no effect, frame completes after 4 more words.
